// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the MIPS32 pipeline datapath and its hazard controller.
// HAZARD_PERF_CNT_EN adds the performance-counter outputs.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_jump;
    logic        id_jr;
    logic        ex_MemRead;
    logic [4:0]  ex_rt;
    logic        mem_branch_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        halt_req;

    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_write;
    logic        idex_flush;
    logic        exmem_write;
    logic        exmem_flush;
    logic        memwb_bubble;
    logic        halted;
    logic        mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] wait_cnt_total;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt, id_jump, id_jr, ex_MemRead, ex_rt,
               mem_branch_taken, dmem_req, dmem_ready, halt_req,
        input  pc_write, pc_sel, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, exmem_flush, memwb_bubble, halted, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cnt, flush_cnt, wait_cnt_total
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_jump, id_jr, ex_MemRead, ex_rt,
               mem_branch_taken, dmem_req, dmem_ready, halt_req,
        output pc_write, pc_sel, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, exmem_flush, memwb_bubble, halted, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cnt, flush_cnt, wait_cnt_total
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS32 pipeline: stalls, redirects, memory freezes, debug halt.
// Define HAZARD_PERF_CNT_EN to add stall/flush/wait performance counters.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_RUN     | normal execution, hazard priority applied every cycle
//   ST_MEMWAIT | data memory stalled; pipeline frozen until ready/timeout
//   ST_DRAIN   | fetch stopped, younger stages flushed, older ones retire
//   ST_HALTED  | pipeline empty and stopped until halt_req drops
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 15
) (
    input logic              clk,
    input logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } state_e;

    localparam logic [7:0] MEM_TIMEOUT_C = 8'(MEM_TIMEOUT);
    localparam logic [7:0] DRAIN_LAST_C  = 8'(DRAIN_CYCLES - 1);
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    state_e     state_q, state_d;
    logic       prior_drain_q, prior_drain_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] drain_cnt_q, drain_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic       freeze, timed_out, loaduse, in_drain;
    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic       exmem_write, exmem_flush, memwb_bubble, halted;
    logic [1:0] pc_sel;

    assign freeze    = bus.dmem_req & ~bus.dmem_ready & (wait_cnt_q != MEM_TIMEOUT_C);
    assign timed_out = bus.dmem_req & ~bus.dmem_ready & (wait_cnt_q == MEM_TIMEOUT_C);
    assign loaduse   = bus.ex_MemRead & (bus.ex_rt != 5'd0) &
                       ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));
    // MEMWAIT resumes whichever mode it interrupted, so drain behaviour follows the saved mode.
    assign in_drain  = (state_q == ST_DRAIN) | ((state_q == ST_MEMWAIT) & prior_drain_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            prior_drain_q <= 1'b0;
            wait_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prior_drain_q <= prior_drain_d;
            wait_cnt_q    <= wait_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        prior_drain_d = prior_drain_q;
        wait_cnt_d    = wait_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        mem_timeout_d = mem_timeout_q;
        pc_write      = 1'b1;
        pc_sel        = PC_SEQ;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_write    = 1'b1;
        idex_flush    = 1'b0;
        exmem_write   = 1'b1;
        exmem_flush   = 1'b0;
        memwb_bubble  = 1'b0;
        halted        = 1'b0;

        if (!reset) begin
            if (state_q == ST_HALTED) begin
                halted       = 1'b1;
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                memwb_bubble = 1'b1;
                if (!bus.halt_req) state_d = ST_RUN;
            end else if (freeze) begin
                pc_write      = 1'b0;
                ifid_write    = 1'b0;
                idex_write    = 1'b0;
                exmem_write   = 1'b0;
                memwb_bubble  = 1'b1;
                wait_cnt_d    = wait_cnt_q + 8'd1;
                prior_drain_d = in_drain;
                state_d       = ST_MEMWAIT;
            end else begin
                wait_cnt_d = '0;
                if (timed_out) mem_timeout_d = 1'b1;

                if (bus.mem_branch_taken) begin
                    pc_sel      = PC_BR;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (bus.id_jr) begin
                    pc_sel     = PC_JR;
                    ifid_flush = 1'b1;
                end else if (bus.id_jump) begin
                    pc_sel     = PC_J;
                    ifid_flush = 1'b1;
                end else if (loaduse) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end

                if (in_drain) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    if (!bus.halt_req) begin
                        state_d     = ST_RUN;
                        drain_cnt_d = '0;
                    end else if (drain_cnt_q == DRAIN_LAST_C) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = '0;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = drain_cnt_q + 8'd1;
                    end
                end else begin
                    state_d = bus.halt_req ? ST_DRAIN : ST_RUN;
                end
            end
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.pc_sel       = pc_sel;
    assign bus.ifid_write   = ifid_write;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_write   = idex_write;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_write  = exmem_write;
    assign bus.exmem_flush  = exmem_flush;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.halted       = halted;
    assign bus.mem_timeout  = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, wait_total_q;
    logic        active, redirect, ev_stall, ev_flush, ev_wait;

    assign active   = (state_q != ST_HALTED);
    assign redirect = bus.mem_branch_taken | bus.id_jr | bus.id_jump;
    assign ev_wait  = active & freeze;
    assign ev_flush = active & ~freeze & redirect;
    assign ev_stall = active & ~freeze & ~redirect & loaduse;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            wait_total_q <= '0;
        end else begin
            if (ev_stall) stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (ev_flush) flush_cnt_q  <= flush_cnt_q + 32'd1;
            if (ev_wait)  wait_total_q <= wait_total_q + 32'd1;
        end
    end

    assign bus.stall_cnt      = stall_cnt_q;
    assign bus.flush_cnt      = flush_cnt_q;
    assign bus.wait_cnt_total = wait_total_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios then randomized traffic,
// each cycle checked against a behavioural pipeline-control model.
module tb_pipe_hazard_ctrl;
    localparam int DRAIN_CYCLES = 4;
    localparam int MEM_TIMEOUT  = 15;

    logic clk = 1'b1;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz();
    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hz)
    );

    typedef struct {
        logic [11:0] exp;
        string       tag;
        int          cyc;
    } sb_t;

    sb_t sbq[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    // model: how long memory has been stuck, whether we are draining/halted, sticky timeout
    bit m_halted  = 0;
    bit m_drain   = 0;
    bit m_timeout = 0;
    int m_wait    = 0;
    int m_drain_n = 0;

    // vector order: pc_write pc_sel ifid_w ifid_f idex_w idex_f exmem_w exmem_f memwb_bubble halted mem_timeout
    task automatic model_cycle(output logic [11:0] e);
        bit pw, iw, ifl, xw, xfl, ew, efl, mb, h, stuck, hit, new_to;
        logic [1:0] ps;
        pw = 1; iw = 1; ifl = 0; xw = 1; xfl = 0; ew = 1; efl = 0; mb = 0; h = 0; ps = 2'b00;
        new_to = 0;
        stuck = hz.dmem_req && !hz.dmem_ready;
        hit = hz.ex_MemRead && (hz.ex_rt != 0) &&
              ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
        if (reset) begin
            // defaults already loaded
        end else if (m_halted) begin
            pw = 0; iw = 0; xw = 0; ew = 0; mb = 1; h = 1;
            if (!hz.halt_req) m_halted = 0;
        end else if (stuck && m_wait < MEM_TIMEOUT) begin
            pw = 0; iw = 0; xw = 0; ew = 0; mb = 1;
            m_wait = m_wait + 1;
        end else begin
            new_to = stuck && (m_wait == MEM_TIMEOUT);
            m_wait = 0;
            if (hz.mem_branch_taken) begin
                ps = 2'b01; ifl = 1; xfl = 1; efl = 1;
            end else if (hz.id_jr) begin
                ps = 2'b11; ifl = 1;
            end else if (hz.id_jump) begin
                ps = 2'b10; ifl = 1;
            end else if (hit) begin
                pw = 0; iw = 0; xfl = 1;
            end
            if (m_drain) begin
                pw = 0; ifl = 1;
                if (!hz.halt_req) begin
                    m_drain = 0; m_drain_n = 0;
                end else begin
                    m_drain_n = m_drain_n + 1;
                    if (m_drain_n == DRAIN_CYCLES) begin
                        m_drain = 0; m_drain_n = 0; m_halted = 1;
                    end
                end
            end else if (hz.halt_req) begin
                m_drain = 1;
            end
        end
        e = {pw, ps, iw, ifl, xw, xfl, ew, efl, mb, h, m_timeout};
        if (reset) begin
            m_halted = 0; m_drain = 0; m_timeout = 0; m_wait = 0; m_drain_n = 0;
        end else if (new_to) begin
            m_timeout = 1;
        end
    endtask

    task automatic idle_inputs();
        reset               = 1'b0;
        hz.id_rs            = 5'd7;
        hz.id_rt            = 5'd8;
        hz.id_uses_rt       = 1'b0;
        hz.id_jump          = 1'b0;
        hz.id_jr            = 1'b0;
        hz.ex_MemRead       = 1'b0;
        hz.ex_rt            = 5'd9;
        hz.mem_branch_taken = 1'b0;
        hz.dmem_req         = 1'b0;
        hz.dmem_ready       = 1'b0;
        hz.halt_req         = 1'b0;
    endtask

    task automatic step(input string tag);
        logic [11:0] e;
        sb_t item;
        model_cycle(e);
        item.exp = e;
        item.tag = tag;
        item.cyc = cyc;
        sbq.push_back(item);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        sb_t it;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                it = sbq.pop_front();
                act = {hz.pc_write, hz.pc_sel, hz.ifid_write, hz.ifid_flush, hz.idex_write,
                       hz.idex_flush, hz.exmem_write, hz.exmem_flush, hz.memwb_bubble,
                       hz.halted, hz.mem_timeout};
                n_vec++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d: got %03h expected %03h", it.tag, it.cyc, act, it.exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors checked", n_vec);
        $fatal(1);
    end

    initial begin
        bit slow;
        idle_inputs();
        reset = 1'b1;
        step("reset");
        step("reset");
        idle_inputs();
        repeat (2) step("idle");

        hz.ex_MemRead = 1; hz.ex_rt = 5'd2; hz.id_rs = 5'd2;
        step("loaduse_rs");
        hz.ex_MemRead = 0;
        step("loaduse_release");
        idle_inputs();
        hz.ex_MemRead = 1; hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
        step("loaduse_r0");
        idle_inputs();
        hz.ex_MemRead = 1; hz.ex_rt = 5'd5; hz.id_rt = 5'd5; hz.id_uses_rt = 1;
        step("loaduse_rt");
        hz.id_uses_rt = 0;
        step("loaduse_rt_unused");

        hz.ex_rt = 5'd7; hz.id_uses_rt = 1; hz.id_rt = 5'd7; hz.mem_branch_taken = 1;
        step("branch_over_loaduse");
        idle_inputs();
        hz.id_jump = 1; step("jump");
        hz.id_jr = 1;   step("jr_over_jump");
        idle_inputs();

        hz.dmem_req = 1;
        repeat (3) step("memwait3");
        hz.dmem_ready = 1;
        step("memwait_ready");
        idle_inputs();
        step("memwait_after");

        hz.dmem_req = 1;
        repeat (MEM_TIMEOUT + 1) step("timeout_wait");
        hz.dmem_req = 0;
        repeat (2) step("timeout_sticky");

        hz.halt_req = 1;
        step("halt_run");
        repeat (DRAIN_CYCLES) step("drain");
        repeat (2) step("halted");
        hz.halt_req = 0;
        step("halted_release");
        step("resume");

        hz.dmem_req = 1;
        repeat (2) step("rst_memwait_pre");
        reset = 1;
        step("rst_in_memwait");
        idle_inputs();
        step("rst_after");

        for (int i = 0; i < 3000; i++) begin
            slow = ((i / 250) % 2) == 1;
            reset               = ($urandom_range(0, 399) == 0);
            hz.id_rs            = 5'($urandom_range(0, 3));
            hz.id_rt            = 5'($urandom_range(0, 3));
            hz.ex_rt            = 5'($urandom_range(0, 3));
            hz.id_uses_rt       = 1'($urandom_range(0, 1));
            hz.ex_MemRead       = 1'($urandom_range(0, 1));
            hz.mem_branch_taken = ($urandom_range(0, 7) == 0);
            hz.id_jump          = ($urandom_range(0, 7) == 0);
            hz.id_jr            = ($urandom_range(0, 7) == 0);
            hz.dmem_req         = slow ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            hz.dmem_ready       = slow ? ($urandom_range(0, 29) == 0) : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) hz.halt_req = ~hz.halt_req;
            step("random");
        end

        for (int k = 0; k < 10 && sbq.size() != 0; k++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
